// File: rtl/apu_mixer.sv
// apu_mixer: collects one 1-bit sample from each of NUM_CH channel streams, weights each
// sample by its channel volume, and emits the sum as a multi-bit sample stream and as a
// first-order sigma-delta (PDM) bitstream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_data/ch_vld/ch_rdy per-channel 1-bit sample streams (bit i = channel i)
//   vol_data/vol_vld      packed per-channel volumes, channel i at [i*VOL_W +: VOL_W]
//   vol_rdy               always 1
//   sample/sample_vld/sample_rdy  mixed level stream
//   pdm_out               registered sigma-delta bitstream of the last accepted level
module apu_mixer #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned VOL_W  = 4,
  parameter int unsigned SUM_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_data,
  input  logic [NUM_CH-1:0]       ch_vld,
  output logic [NUM_CH-1:0]       ch_rdy,
  input  logic [NUM_CH*VOL_W-1:0] vol_data,
  input  logic                    vol_vld,
  output logic                    vol_rdy,
  output logic [SUM_W-1:0]        sample,
  output logic                    sample_vld,
  input  logic                    sample_rdy,
  output logic                    pdm_out
);

  typedef enum logic [0:0] {StCollect, StEmit} state_e;

  state_e                    state_q, state_d;
  logic [NUM_CH-1:0]         captured_q, captured_d;
  logic [NUM_CH-1:0]         hold_q, hold_d;
  logic [NUM_CH*VOL_W-1:0]   vol_q, vol_d;
  logic [SUM_W-1:0]          sample_q, sample_d;
  logic                      sample_vld_q, sample_vld_d;
  logic [SUM_W-1:0]          level_q, level_d;
  logic [SUM_W-1:0]          acc_q, acc_d;
  logic                      pdm_q, pdm_d;

  logic [NUM_CH-1:0]         ch_hs;
  logic [SUM_W-1:0]          mix;
  logic [SUM_W:0]            pdm_sum;

  always_comb begin
    state_d      = state_q;
    captured_d   = captured_q;
    hold_d       = hold_q;
    sample_d     = sample_q;
    sample_vld_d = sample_vld_q;
    level_d      = level_q;
    vol_d        = vol_q;
    mix          = '0;

    ch_rdy = (state_q == StCollect) ? ~captured_q : '0;
    ch_hs  = ch_vld & ch_rdy;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_hs[i]) hold_d[i] = ch_data[i];
    end
    captured_d = captured_q | ch_hs;

    // Uses the volumes currently held; a vol_vld on this same edge applies to the next mix.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hold_d[i]) mix = mix + SUM_W'(vol_q[i*VOL_W +: VOL_W]);
    end

    unique case (state_q)
      StCollect: begin
        if (&captured_d) begin
          sample_d     = mix;
          sample_vld_d = 1'b1;
          state_d      = StEmit;
        end
      end
      StEmit: begin
        if (sample_rdy) begin
          level_d      = sample_q;
          sample_vld_d = 1'b0;
          captured_d   = '0;
          state_d      = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase

    if (vol_vld) vol_d = vol_data;

    // First-order sigma-delta: the carry out of the phase accumulator is the PDM bit.
    pdm_sum = {1'b0, acc_q} + {1'b0, level_q};
    acc_d   = pdm_sum[SUM_W-1:0];
    pdm_d   = pdm_sum[SUM_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCollect;
      captured_q   <= '0;
      hold_q       <= '0;
      vol_q        <= '1;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      level_q      <= '0;
      acc_q        <= '0;
      pdm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      captured_q   <= captured_d;
      hold_q       <= hold_d;
      vol_q        <= vol_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      level_q      <= level_d;
      acc_q        <= acc_d;
      pdm_q        <= pdm_d;
    end
  end

  assign vol_rdy    = 1'b1;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign pdm_out    = pdm_q;

endmodule
